// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared widths, default sizing and grant-source encoding for the regfile write-port arbiter.
package regfile_wr_arbiter_pkg;

  localparam int REG_ADDR_W        = 5;
  localparam int REG_DATA_W        = 32;
  localparam int WR_ARB_DEPTH_DEF  = 2;
  localparam int WR_ARB_STARVE_DEF = 4;

  typedef enum logic [1:0] {
    WR_SRC_NONE = 2'd0,
    WR_SRC_WB   = 2'd1,
    WR_SRC_AUX  = 2'd2
  } wr_src_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } aux_entry_t;

endpackage

// File: rtl/regfile_wr_arbiter_fifo.sv
// Synchronous FIFO buffering aux results ahead of the regfile write port.
// Build option WR_ARB_BYPASS_EN also exposes every entry, oldest first, for operand bypass.
module regfile_wr_arbiter_fifo
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DEPTH = WR_ARB_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [REG_ADDR_W-1:0] i_push_addr,
  input  logic [REG_DATA_W-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [REG_ADDR_W-1:0] o_head_addr,
  output logic [REG_DATA_W-1:0] o_head_data,
  output logic                  o_empty,
  output logic                  o_ready
`ifdef WR_ARB_BYPASS_EN
  ,
  output logic [DEPTH-1:0]            o_ent_valid,
  output logic [DEPTH*REG_ADDR_W-1:0] o_ent_addr,
  output logic [DEPTH*REG_DATA_W-1:0] o_ent_data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  aux_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ready;
  logic [CNT_W-1:0] w_count_next;

  assign w_count_next = r_count + CNT_W'(i_push) - CNT_W'(i_pop);
  assign o_empty      = (r_count == '0);
  assign o_ready      = r_ready;
  assign o_head_addr  = r_mem[r_rd_ptr].addr;
  assign o_head_data  = r_mem[r_rd_ptr].data;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
      // Ready is a flop of the next-cycle occupancy: no combinational path from pop to ready.
      r_ready <= (w_count_next != CNT_W'(DEPTH));
    end
  end

  // NOTE: entry storage is not reset; validity lives entirely in the pointers and count.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= '{addr: i_push_addr, data: i_push_data};
  end

`ifdef WR_ARB_BYPASS_EN
  always_comb begin
    o_ent_valid = '0;
    o_ent_addr  = '0;
    o_ent_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_ent_valid[i]                         = (i < int'(r_count));
      o_ent_addr[i*REG_ADDR_W +: REG_ADDR_W] = r_mem[r_rd_ptr + PTR_W'(i)].addr;
      o_ent_data[i*REG_DATA_W +: REG_DATA_W] = r_mem[r_rd_ptr + PTR_W'(i)].data;
    end
  end
`endif

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the single regfile write port between writeback (primary) and buffered aux results.
// Build option WR_ARB_BYPASS_EN adds a youngest-match search of the aux buffer for operand bypass.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = WR_ARB_DEPTH_DEF,
  parameter int STARVE_LIMIT = WR_ARB_STARVE_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_wr_enable,
  input  logic [REG_ADDR_W-1:0] wb_wr_addr,
  input  logic [REG_DATA_W-1:0] wb_wr_data,
  output logic                  wb_stall,
  input  logic                  aux_valid,
  output logic                  aux_ready,
  input  logic [REG_ADDR_W-1:0] aux_rd_addr,
  input  logic [REG_DATA_W-1:0] aux_result,
  output logic                  aux_pending,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [REG_DATA_W-1:0] wr_data,
  output logic                  wr_enable
`ifdef WR_ARB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0] byp_rs_addr,
  output logic                  byp_hit,
  output logic [REG_DATA_W-1:0] byp_data
`endif
);

  localparam int STV_W = $clog2(STARVE_LIMIT) + 1;

  logic [STV_W-1:0]      r_starve;
  logic                  r_force;
  wr_src_e               w_src;
  logic                  w_discard;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_denied;
  logic                  w_empty;
  logic [REG_ADDR_W-1:0] w_head_addr;
  logic [REG_DATA_W-1:0] w_head_data;
`ifdef WR_ARB_BYPASS_EN
  logic [FIFO_DEPTH-1:0]            w_ent_valid;
  logic [FIFO_DEPTH*REG_ADDR_W-1:0] w_ent_addr;
  logic [FIFO_DEPTH*REG_DATA_W-1:0] w_ent_data;
`endif

  // Results for x0 are acknowledged but never stored.
  assign w_push = aux_valid && aux_ready && (aux_rd_addr != '0);

  regfile_wr_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_addr (aux_rd_addr),
    .i_push_data (aux_result),
    .i_pop       (w_pop),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_empty     (w_empty),
    .o_ready     (aux_ready)
`ifdef WR_ARB_BYPASS_EN
    ,
    .o_ent_valid (w_ent_valid),
    .o_ent_addr  (w_ent_addr),
    .o_ent_data  (w_ent_data)
`endif
  );

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    w_src     = WR_SRC_NONE;
    w_discard = 1'b0;
    wb_stall  = 1'b0;
    if (!reset) begin
      if (r_force && !w_empty) begin
        w_src    = WR_SRC_AUX;
        wb_stall = wb_wr_enable;
      end else if (wb_wr_enable) begin
        w_src     = WR_SRC_WB;
        // The writeback value is newer than a buffered head for the same register.
        w_discard = !w_empty && (w_head_addr == wb_wr_addr);
      end else if (!w_empty) begin
        w_src = WR_SRC_AUX;
      end
    end
  end

  assign w_pop       = (w_src == WR_SRC_AUX) || w_discard;
  assign w_denied    = !w_empty && !w_pop;
  assign wr_addr     = (w_src == WR_SRC_AUX) ? w_head_addr : wb_wr_addr;
  assign wr_data     = (w_src == WR_SRC_AUX) ? w_head_data : wb_wr_data;
  assign wr_enable   = (w_src != WR_SRC_NONE) && (wr_addr != '0);
  assign aux_pending = !w_empty;

  // Starvation: after STARVE_LIMIT-1 denied cycles the head takes the port for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
      r_force  <= 1'b0;
    end else if (w_denied) begin
      if (r_starve != STV_W'(STARVE_LIMIT - 1)) r_starve <= r_starve + STV_W'(1);
      r_force <= (r_starve >= STV_W'(STARVE_LIMIT - 2));
    end else begin
      r_starve <= '0;
      r_force  <= 1'b0;
    end
  end

`ifdef WR_ARB_BYPASS_EN
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_ent_valid[i] && (byp_rs_addr != '0) &&
          (w_ent_addr[i*REG_ADDR_W +: REG_ADDR_W] == byp_rs_addr)) begin
        byp_hit  = 1'b1;
        byp_data = w_ent_data[i*REG_DATA_W +: REG_DATA_W];
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: expected regfile writes are queued as stimulus is
// driven and popped by a monitor whenever the DUT strobes wr_enable.
module tb_regfile_wr_arbiter;
  import regfile_wr_arbiter_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  wb_wr_enable;
  logic [REG_ADDR_W-1:0] wb_wr_addr;
  logic [REG_DATA_W-1:0] wb_wr_data;
  logic                  wb_stall;
  logic                  aux_valid;
  logic                  aux_ready;
  logic [REG_ADDR_W-1:0] aux_rd_addr;
  logic [REG_DATA_W-1:0] aux_result;
  logic                  aux_pending;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [REG_DATA_W-1:0] wr_data;
  logic                  wr_enable;
`ifdef WR_ARB_BYPASS_EN
  logic [REG_ADDR_W-1:0] byp_rs_addr;
  logic                  byp_hit;
  logic [REG_DATA_W-1:0] byp_data;
`endif

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_tests = 0;
  int  n_fail  = 0;
  int  n_wb    = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .wb_wr_enable (wb_wr_enable),
    .wb_wr_addr   (wb_wr_addr),
    .wb_wr_data   (wb_wr_data),
    .wb_stall     (wb_stall),
    .aux_valid    (aux_valid),
    .aux_ready    (aux_ready),
    .aux_rd_addr  (aux_rd_addr),
    .aux_result   (aux_result),
    .aux_pending  (aux_pending),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_enable    (wr_enable)
`ifdef WR_ARB_BYPASS_EN
    ,
    .byp_rs_addr  (byp_rs_addr),
    .byp_hit      (byp_hit),
    .byp_data     (byp_data)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_wr_enable = 1'b0;
    wb_wr_addr   = '0;
    wb_wr_data   = '0;
    aux_valid    = 1'b0;
    aux_rd_addr  = '0;
    aux_result   = '0;
`ifdef WR_ARB_BYPASS_EN
    byp_rs_addr  = '0;
`endif
  endtask

  task automatic drive_wb(input logic [REG_ADDR_W-1:0] a, input logic [REG_DATA_W-1:0] d);
    wb_wr_enable = 1'b1;
    wb_wr_addr   = a;
    wb_wr_data   = d;
  endtask

  task automatic drive_aux(input logic [REG_ADDR_W-1:0] a, input logic [REG_DATA_W-1:0] d);
    aux_valid   = 1'b1;
    aux_rd_addr = a;
    aux_result  = d;
  endtask

  task automatic expect_wr(input logic [REG_ADDR_W-1:0] a, input logic [REG_DATA_W-1:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  // Monitor: every regfile write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wr_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr", wr_enable, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", wr_addr, mon_e.addr);
        check("wr_data", wr_data, mon_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    @(negedge clk);
    check("rst_wr_enable", wr_enable, 1'b0);
    check("rst_wb_stall", wb_stall, 1'b0);
    check("rst_aux_ready", aux_ready, 1'b0);
    check("rst_aux_pending", aux_pending, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("ready_after_reset", aux_ready, 1'b1);

    // 1: continuous writeback to x5, no aux traffic
    for (int k = 0; k < 4; k++) begin
      tick();
      drive_wb(5, 32'hA);
      expect_wr(5, 32'hA);
      @(negedge clk);
      check("t1_wb_stall", wb_stall, 1'b0);
    end
    tick();
    idle_inputs();

    // 2: single aux result drained into an idle writeback cycle
    tick();
    drive_aux(7, 32'h1234);
    expect_wr(7, 32'h1234);
    @(negedge clk);
    check("t2_pending_pre", aux_pending, 1'b0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("t2_pending_during", aux_pending, 1'b1);
    check("t2_wr_enable", wr_enable, 1'b1);
    tick();
    @(negedge clk);
    check("t2_pending_after", aux_pending, 1'b0);
    check("t2_drain", exp_q.size(), 0);

    // 3: writeback saturates the port; aux forced through after 3 denied cycles, twice
    n_wb = 0;
    for (int k = 0; k <= 10; k++) begin
      tick();
      idle_inputs();
      drive_wb(3, 32'h300 + n_wb);
      if (k == 0) drive_aux(7, 32'h77);
      if (k == 5) drive_aux(8, 32'h88);
      if (k == 4) expect_wr(7, 32'h77);
      else if (k == 9) expect_wr(8, 32'h88);
      else begin
        expect_wr(3, 32'h300 + n_wb);
        n_wb++;
      end
      @(negedge clk);
      check("t3_wb_stall", wb_stall, (k == 4 || k == 9));
      if (k == 5) begin
        check("t3_pending_cleared", aux_pending, 1'b0);
        check("t3_ready", aux_ready, 1'b1);
      end
    end
    tick();
    idle_inputs();
    @(negedge clk);
    check("t3_drain", exp_q.size(), 0);

    // x0 handling: wb write to x0 granted but suppressed, aux result for x0 dropped
    tick();
    drive_wb(0, 32'hDEAD);
    drive_aux(0, 32'hBEEF);
    @(negedge clk);
    check("x0_wr_enable", wr_enable, 1'b0);
    check("x0_wb_stall", wb_stall, 1'b0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("x0_aux_pending", aux_pending, 1'b0);

    // 4: same-address supersede of the FIFO head
    tick();
    drive_aux(9, 32'h1);
    @(negedge clk);
    tick();
    idle_inputs();
    drive_wb(9, 32'h2);
    expect_wr(9, 32'h2);
    @(negedge clk);
    check("t4_wb_stall", wb_stall, 1'b0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("t4_pending", aux_pending, 1'b0);
    tick();
    @(negedge clk);
    check("t4_drain", exp_q.size(), 0);

    // 5: fill the FIFO behind busy writeback, then reset discards it
    tick();
    drive_wb(1, 32'h100);
    drive_aux(10, 32'hA0);
    expect_wr(1, 32'h100);
    @(negedge clk);
    tick();
    drive_wb(1, 32'h101);
    drive_aux(11, 32'hB0);
    expect_wr(1, 32'h101);
    @(negedge clk);
    check("t5_ready_one", aux_ready, 1'b1);
    tick();
    idle_inputs();
    drive_wb(1, 32'h102);
    expect_wr(1, 32'h102);
    @(negedge clk);
    check("t5_ready_full", aux_ready, 1'b0);
    check("t5_pending_full", aux_pending, 1'b1);
    tick();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_wr_enable", wr_enable, 1'b0);
    tick();
    @(negedge clk);
    check("t5_rst_ready", aux_ready, 1'b0);
    check("t5_rst_pending", aux_pending, 1'b0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    @(negedge clk);
    check("t5_post_pending", aux_pending, 1'b0);
    check("t5_drain", exp_q.size(), 0);

`ifdef WR_ARB_BYPASS_EN
    // 6: youngest buffered result for x4 is bypassed
    tick();
    drive_wb(1, 32'h600);
    drive_aux(4, 32'h11);
    expect_wr(1, 32'h600);
    @(negedge clk);
    tick();
    drive_wb(1, 32'h601);
    drive_aux(4, 32'h22);
    expect_wr(1, 32'h601);
    @(negedge clk);
    tick();
    idle_inputs();
    drive_wb(1, 32'h602);
    expect_wr(1, 32'h602);
    byp_rs_addr = 4;
    @(negedge clk);
    check("t6_byp_hit", byp_hit, 1'b1);
    check("t6_byp_data", byp_data, 32'h22);
    byp_rs_addr = 0;
    #1;
    check("t6_byp_x0", byp_hit, 1'b0);
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("t6_drain", exp_q.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
